// File: rtl/posit_mult_pipe.sv
// posit_mult_pipe
// Three-stage multiplier for decoded posit operands. Each operand arrives
// as {flags, sign, biased exponent, fraction below an implicit hidden 1}.
// The result carries the exact (unrounded) mantissa product and the plain
// sum of the exponents, so the bias is doubled in the output.
//
// Parameters
//   FRAC_W : fraction width of each operand (hidden bit not stored)
//   EXP_W  : biased exponent width of each operand
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand-pair handshake (in_ready == global advance)
//   l_*/r_*              : left/right operand {inf,zero} flags, sign, exp, frac
//   out_valid / out_ready: result handshake
//   out_flags            : {inf,zero} of the result, 2'b11 = NaN
//   out_sign, out_exp    : result sign, exponent (EXP_W+1 bits, doubled bias)
//   out_frac             : exact result fraction below the hidden bit
//   nan_seen             : sticky, set when a NaN result is transferred out
//   op_count             : wrapping count of output transfers
module posit_mult_pipe #(
  parameter int FRAC_W = 5,
  parameter int EXP_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          l_flags,
  input  logic [1:0]          r_flags,
  input  logic                l_sign,
  input  logic                r_sign,
  input  logic [EXP_W-1:0]    l_exp,
  input  logic [EXP_W-1:0]    r_exp,
  input  logic [FRAC_W-1:0]   l_frac,
  input  logic [FRAC_W-1:0]   r_frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_flags,
  output logic                out_sign,
  output logic [EXP_W:0]      out_exp,
  output logic [2*FRAC_W:0]   out_frac,
  output logic                nan_seen,
  output logic [15:0]         op_count
);

  localparam int PW = 2*FRAC_W + 2;
  localparam int XW = EXP_W + 1;

  // A product of two values in [1,2) lies in [1,4); the top bit says which
  // half, and the fraction is left-aligned so the hidden bit is dropped.
  function automatic logic [PW-2:0] norm_frac(input logic [PW-1:0] p);
    if (p[PW-1]) return p[PW-2:0];
    else         return {p[PW-3:0], 1'b0};
  endfunction

  function automatic logic [XW-1:0] norm_exp(input logic [XW-1:0] e,
                                             input logic [PW-1:0] p);
    return e + XW'(p[PW-1]);
  endfunction

  logic adv, out_xfer;

  logic              vld_p0_d, vld_p0_q;
  logic [1:0]        l_flags_p0_d, l_flags_p0_q, r_flags_p0_d, r_flags_p0_q;
  logic              l_sign_p0_d, l_sign_p0_q, r_sign_p0_d, r_sign_p0_q;
  logic [EXP_W-1:0]  l_exp_p0_d, l_exp_p0_q, r_exp_p0_d, r_exp_p0_q;
  logic [FRAC_W-1:0] l_frac_p0_d, l_frac_p0_q, r_frac_p0_d, r_frac_p0_q;

  logic              vld_p1_d, vld_p1_q;
  logic [1:0]        flags_p1_d, flags_p1_q;
  logic              sign_p1_d, sign_p1_q;
  logic [XW-1:0]     exp_p1_d, exp_p1_q;
  logic [PW-1:0]     prod_p1_d, prod_p1_q;

  logic              vld_p2_d, vld_p2_q;
  logic [1:0]        flags_p2_d, flags_p2_q;
  logic              sign_p2_d, sign_p2_q;
  logic [XW-1:0]     exp_p2_d, exp_p2_q;
  logic [PW-2:0]     frac_p2_d, frac_p2_q;

  logic              nan_seen_d, nan_seen_q;
  logic [15:0]       op_count_d, op_count_q;

  always_comb begin
    // The whole pipe moves as one; a stalled full output freezes every stage.
    adv      = out_ready | ~vld_p2_q;
    out_xfer = vld_p2_q & out_ready;

    vld_p0_d     = vld_p0_q;
    l_flags_p0_d = l_flags_p0_q;
    r_flags_p0_d = r_flags_p0_q;
    l_sign_p0_d  = l_sign_p0_q;
    r_sign_p0_d  = r_sign_p0_q;
    l_exp_p0_d   = l_exp_p0_q;
    r_exp_p0_d   = r_exp_p0_q;
    l_frac_p0_d  = l_frac_p0_q;
    r_frac_p0_d  = r_frac_p0_q;
    vld_p1_d     = vld_p1_q;
    flags_p1_d   = flags_p1_q;
    sign_p1_d    = sign_p1_q;
    exp_p1_d     = exp_p1_q;
    prod_p1_d    = prod_p1_q;
    vld_p2_d     = vld_p2_q;
    flags_p2_d   = flags_p2_q;
    sign_p2_d    = sign_p2_q;
    exp_p2_d     = exp_p2_q;
    frac_p2_d    = frac_p2_q;

    if (adv) begin
      // stage p0: operand capture
      vld_p0_d     = in_valid;
      l_flags_p0_d = l_flags;
      r_flags_p0_d = r_flags;
      l_sign_p0_d  = l_sign;
      r_sign_p0_d  = r_sign;
      l_exp_p0_d   = l_exp;
      r_exp_p0_d   = r_exp;
      l_frac_p0_d  = l_frac;
      r_frac_p0_d  = r_frac;

      // stage p1: mantissa product and exponent sum
      vld_p1_d   = vld_p0_q;
      flags_p1_d = l_flags_p0_q | r_flags_p0_q;
      sign_p1_d  = l_sign_p0_q ^ r_sign_p0_q;
      exp_p1_d   = XW'(l_exp_p0_q) + XW'(r_exp_p0_q);
      prod_p1_d  = PW'({1'b1, l_frac_p0_q}) * PW'({1'b1, r_frac_p0_q});

      // stage p2: normalise, zero the payload of special values
      vld_p2_d   = vld_p1_q;
      flags_p2_d = flags_p1_q;
      if (|flags_p1_q) begin
        sign_p2_d = 1'b0;
        exp_p2_d  = '0;
        frac_p2_d = '0;
      end else begin
        sign_p2_d = sign_p1_q;
        exp_p2_d  = norm_exp(exp_p1_q, prod_p1_q);
        frac_p2_d = norm_frac(prod_p1_q);
      end
    end

    nan_seen_d = nan_seen_q | (out_xfer && (flags_p2_q == 2'b11));
    op_count_d = op_count_q + {15'd0, out_xfer};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      flags_p2_q <= '0;
      sign_p2_q  <= 1'b0;
      exp_p2_q   <= '0;
      frac_p2_q  <= '0;
      nan_seen_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      flags_p2_q <= flags_p2_d;
      sign_p2_q  <= sign_p2_d;
      exp_p2_q   <= exp_p2_d;
      frac_p2_q  <= frac_p2_d;
      nan_seen_q <= nan_seen_d;
      op_count_q <= op_count_d;
    end
  end

  always_ff @(posedge clk) begin
    l_flags_p0_q <= l_flags_p0_d;
    r_flags_p0_q <= r_flags_p0_d;
    l_sign_p0_q  <= l_sign_p0_d;
    r_sign_p0_q  <= r_sign_p0_d;
    l_exp_p0_q   <= l_exp_p0_d;
    r_exp_p0_q   <= r_exp_p0_d;
    l_frac_p0_q  <= l_frac_p0_d;
    r_frac_p0_q  <= r_frac_p0_d;
    flags_p1_q   <= flags_p1_d;
    sign_p1_q    <= sign_p1_d;
    exp_p1_q     <= exp_p1_d;
    prod_p1_q    <= prod_p1_d;
  end

  assign in_ready  = adv;
  assign out_valid = vld_p2_q;
  assign out_flags = flags_p2_q;
  assign out_sign  = sign_p2_q;
  assign out_exp   = exp_p2_q;
  assign out_frac  = frac_p2_q;
  assign nan_seen  = nan_seen_q;
  assign op_count  = op_count_q;

endmodule
